// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - register file writeback: load FIFO, ALU/load arbiter
// with starvation guard, and pending-load scoreboard.
module rf_writeback #(
  parameter int DATA_W     = 28,
  parameter int ADDR_W     = 4,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alu_valid_i,
  output logic                   alu_ready_o,
  input  logic [ADDR_W-1:0]      alu_dest_i,
  input  logic [DATA_W-1:0]      alu_data_i,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  input  logic [ADDR_W-1:0]      ld_dest_i,
  input  logic [DATA_W-1:0]      ld_data_i,
  input  logic                   mark_valid_i,
  input  logic [ADDR_W-1:0]      mark_dest_i,
  output logic [(1<<ADDR_W)-1:0] pend_mask_o,
  output logic                   rf_wen_o,
  output logic [ADDR_W-1:0]      rf_dest_o,
  output logic [DATA_W-1:0]      rf_data_o
);

  localparam int PW   = $clog2(LQ_DEPTH);
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int NREG = 1 << ADDR_W;

  localparam logic [0:0] ALU_PRI  = 1'b0;
  localparam logic [0:0] LD_FORCE = 1'b1;

  logic [ADDR_W-1:0] lq_dest_q [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_dest_q, rf_dest_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic              lq_empty, lq_full, push, pop, alu_win, win;
  logic [ADDR_W-1:0] head_dest, win_dest;
  logic [DATA_W-1:0] head_data, win_data;

  assign lq_empty    = (count_q == '0);
  assign lq_full     = (count_q == (PW+1)'(LQ_DEPTH));
  assign ld_ready_o  = !lq_full;
  assign alu_ready_o = (state_q == ALU_PRI);
  assign push        = ld_valid_i && !lq_full;
  assign head_dest   = lq_dest_q[rd_ptr_q];
  assign head_data   = lq_data_q[rd_ptr_q];

  // Starvation counter only advances while a load is actually waiting.
  always_comb begin
    alu_win  = 1'b0;
    pop      = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    if (state_q == LD_FORCE) begin
      pop      = !lq_empty;
      state_d  = ALU_PRI;
      starve_d = '0;
    end else if (alu_valid_i) begin
      alu_win = 1'b1;
      if (lq_empty) begin
        starve_d = '0;
      end else begin
        starve_d = starve_q + 1'b1;
        if (starve_d == SW'(STARVE_MAX)) state_d = LD_FORCE;
      end
    end else begin
      pop      = !lq_empty;
      starve_d = '0;
    end
  end

  assign win      = alu_win || pop;
  assign win_dest = alu_win ? alu_dest_i : head_dest;
  assign win_data = alu_win ? alu_data_i : head_data;

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    rf_wen_d  = win && (win_dest != '0);
    rf_dest_d = win ? win_dest : rf_dest_q;
    rf_data_d = win ? win_data : rf_data_q;
    pend_d    = pend_q;
    // Set after clear so a same-cycle mark of the popped register survives.
    if (pop) pend_d[head_dest] = 1'b0;
    if (mark_valid_i && (mark_dest_i != '0)) pend_d[mark_dest_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ALU_PRI;
      starve_q  <= '0;
      pend_q    <= '0;
      rf_wen_q  <= 1'b0;
      rf_dest_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      starve_q  <= starve_d;
      pend_q    <= pend_d;
      rf_wen_q  <= rf_wen_d;
      rf_dest_q <= rf_dest_d;
      rf_data_q <= rf_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      lq_dest_q[wr_ptr_q] <= ld_dest_i;
      lq_data_q[wr_ptr_q] <= ld_data_i;
    end
  end

  assign pend_mask_o = pend_q;
  assign rf_wen_o    = rf_wen_q;
  assign rf_dest_o   = rf_dest_q;
  assign rf_data_o   = rf_data_q;

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed bench for rf_writeback with a queue-based
// reference model compared every cycle.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, mark_valid = 1'b0;
  logic [3:0]  alu_dest = '0, ld_dest = '0, mark_dest = '0;
  logic [27:0] alu_data = '0, ld_data = '0;
  logic        alu_ready, ld_ready, rf_wen;
  logic [15:0] pend_mask;
  logic [3:0]  rf_dest;
  logic [27:0] rf_data;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  rf_writeback dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
    .alu_dest_i(alu_dest), .alu_data_i(alu_data),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_dest_i(ld_dest), .ld_data_i(ld_data),
    .mark_valid_i(mark_valid), .mark_dest_i(mark_dest),
    .pend_mask_o(pend_mask),
    .rf_wen_o(rf_wen), .rf_dest_o(rf_dest), .rf_data_o(rf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: load queue, forced-load flag, starvation count, scoreboard.
  typedef struct packed {logic [3:0] d; logic [27:0] v;} ent_t;
  ent_t        lq[$];
  bit          m_force = 1'b0;
  int          m_starve = 0;
  bit [15:0]   m_pend = '0;
  bit          m_wen = 1'b0;
  bit [3:0]    m_dest = '0;
  bit [27:0]   m_data = '0;

  always @(posedge clk or posedge rst) begin : model
    ent_t w;
    bit   have, popped;
    int   sz0;
    if (rst) begin
      lq.delete();
      m_force = 0; m_starve = 0; m_pend = '0;
      m_wen = 0; m_dest = '0; m_data = '0;
    end else begin
      sz0 = lq.size(); have = 0; popped = 0; w = '0;
      if (m_force) begin
        if (sz0 > 0) begin w = lq.pop_front(); have = 1; popped = 1; end
        m_force = 0; m_starve = 0;
      end else if (alu_valid) begin
        w = '{d: alu_dest, v: alu_data}; have = 1;
        if (sz0 > 0) begin
          m_starve++;
          if (m_starve == 3) m_force = 1;
        end else m_starve = 0;
      end else if (sz0 > 0) begin
        w = lq.pop_front(); have = 1; popped = 1; m_starve = 0;
      end else m_starve = 0;
      if (popped) m_pend[w.d] = 1'b0;
      if (mark_valid && mark_dest != 0) m_pend[mark_dest] = 1'b1;
      if (ld_valid && sz0 < 4) lq.push_back('{d: ld_dest, v: ld_data});
      m_wen = have && (w.d != 0);
      if (have) begin m_dest = w.d; m_data = w.v; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_alu_ready", alu_ready, !m_force);
      chk("m_ld_ready", ld_ready, lq.size() < 4);
      chk("m_rf_wen", rf_wen, m_wen);
      chk("m_rf_dest", rf_dest, m_dest);
      chk("m_rf_data", rf_data, m_data);
      chk("m_pend", pend_mask, m_pend);
    end
  end

  int got[$];

  initial begin
    rst = 1'b1;
    cyc(); chk_en = 1'b1;
    cyc();
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_pend", pend_mask, 0);
    rst = 1'b0;
    cyc();

    // ALU write
    alu_valid = 1; alu_dest = 5; alu_data = 28'h0ABCDEF;
    cyc(); alu_valid = 0;
    chk("alu_wen", rf_wen, 1);
    chk("alu_dest", rf_dest, 5);
    chk("alu_data", rf_data, 28'h0ABCDEF);
    cyc();
    chk("alu_wen_drop", rf_wen, 0);
    chk("alu_dest_hold", rf_dest, 5);

    // Load with scoreboard
    mark_valid = 1; mark_dest = 7;
    cyc(); mark_valid = 0;
    chk("ld_pend_set", pend_mask, 16'h0080);
    ld_valid = 1; ld_dest = 7; ld_data = 28'h1234567;
    cyc(); ld_valid = 0;
    chk("ld_no_wen_yet", rf_wen, 0);
    chk("ld_pend_held", pend_mask, 16'h0080);
    cyc();
    chk("ld_wen", rf_wen, 1);
    chk("ld_dest", rf_dest, 7);
    chk("ld_data", rf_data, 28'h1234567);
    chk("ld_pend_clr", pend_mask, 0);
    cyc();

    // r0 suppression
    alu_valid = 1; alu_dest = 0; alu_data = 28'h111; mark_valid = 1; mark_dest = 0;
    cyc(); alu_valid = 0; mark_valid = 0;
    chk("r0_alu_wen", rf_wen, 0);
    chk("r0_pend", pend_mask, 0);
    ld_valid = 1; ld_dest = 0; ld_data = 28'h222;
    cyc(); ld_valid = 0;
    chk("r0_ld_wen_a", rf_wen, 0);
    cyc();
    chk("r0_ld_wen_b", rf_wen, 0);
    chk("r0_ld_ready", ld_ready, 1);
    cyc();

    // FIFO full with ALU busy, fifth load waits for first pop
    got.delete();
    alu_valid = 1; alu_dest = 1;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_dest = 4'(8 + i); ld_data = 28'(28'h100 + i); alu_data = 28'(i);
      cyc();
      if (rf_wen && rf_dest >= 8) got.push_back(rf_dest);
    end
    chk("full_ld_ready", ld_ready, 0);
    ld_dest = 12; ld_data = 28'h10C;
    cyc();
    if (rf_wen && rf_dest >= 8) got.push_back(rf_dest);
    chk("full_first_pop", rf_dest, 8);
    chk("full_ready_again", ld_ready, 1);
    cyc(); ld_valid = 0; alu_valid = 0;
    if (rf_wen && rf_dest >= 8) got.push_back(rf_dest);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rf_wen && rf_dest >= 8) got.push_back(rf_dest);
    end
    chk("drain_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("drain_order%0d", i), got[i], 8 + i);

    // Starvation: one queued load, ALU continuously valid
    alu_valid = 1; alu_dest = 2; alu_data = 28'h200;
    ld_valid = 1; ld_dest = 9; ld_data = 28'h999;
    cyc(); ld_valid = 0;
    chk("starve_ready0", alu_ready, 1);
    for (int k = 1; k <= 3; k++) begin
      alu_data = 28'(28'h200 + k);
      cyc();
      chk($sformatf("starve_dest%0d", k), rf_dest, 2);
      chk($sformatf("starve_data%0d", k), rf_data, 28'h200 + k);
    end
    chk("starve_force", alu_ready, 0);
    cyc();
    chk("starve_ld_dest", rf_dest, 9);
    chk("starve_ld_data", rf_data, 28'h999);
    chk("starve_ready_back", alu_ready, 1);
    alu_valid = 0;
    cyc(); cyc();

    // Set/clear collision
    mark_valid = 1; mark_dest = 3;
    cyc(); mark_valid = 0;
    chk("coll_pend_set", pend_mask, 16'h0008);
    ld_valid = 1; ld_dest = 3; ld_data = 28'h333;
    cyc(); ld_valid = 0; mark_valid = 1; mark_dest = 3;
    cyc(); mark_valid = 0;
    chk("coll_wen", rf_wen, 1);
    chk("coll_dest", rf_dest, 3);
    chk("coll_pend", pend_mask, 16'h0008);

    // Async reset with two loads queued behind a busy ALU
    alu_valid = 1; alu_dest = 4; alu_data = 28'h444;
    ld_valid = 1; ld_dest = 5; ld_data = 28'h555;
    cyc(); ld_dest = 6; ld_data = 28'h666;
    cyc(); ld_valid = 0;
    chk("pre_rst_wen", rf_wen, 1);
    chk("pre_rst_ld_ready", ld_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wen", rf_wen, 0);
    chk("arst_dest", rf_dest, 0);
    chk("arst_data", rf_data, 0);
    chk("arst_pend", pend_mask, 0);
    chk("arst_ld_ready", ld_ready, 1);
    chk("arst_alu_ready", alu_ready, 1);
    alu_valid = 0;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("post_rst_no_wen%0d", i), rf_wen, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
